// File: rtl/add_nbit_seq.sv
// add_nbit_seq: multi-cycle adder/subtractor that processes CHUNK bits per clock.
// The carry ripples through a register from one chunk to the next.
// WIDTH must be an integer multiple of CHUNK. A result takes NCHUNK = WIDTH/CHUNK RUN cycles.
// Optional feature: define ADD_OVERFLOW_EN to add the registered signed-overflow output ovf.
module add_nbit_seq #(
    parameter int WIDTH = 12,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef ADD_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;      // already inverted for subtraction
    logic             carry_reg, carry_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic [WIDTH-1:0] s_reg, s_next;
    logic             co_reg, co_next;
`ifdef ADD_OVERFLOW_EN
    logic             ovf_reg, ovf_next;
`endif

    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] s_merge;
    logic             accept;

    // Select the operand chunk addressed by the chunk index.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_reg == IW'(k)) begin
                a_chunk = a_reg[k*CHUNK +: CHUNK];
                b_chunk = b_reg[k*CHUNK +: CHUNK];
            end
        end
    end

    assign sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_reg};

    // Only the addressed chunk of s is replaced; the rest keeps its value.
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            localparam logic [IW-1:0] GI = IW'(gi);
            assign s_merge[gi*CHUNK +: CHUNK] =
                (idx_reg == GI) ? sum[CHUNK-1:0] : s_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    // A request is only taken when no operation is in flight.
    assign accept = start && (state_reg == IDLE || state_reg == DONE);

    // Next-state and datapath update; defaults hold every register.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        carry_next = carry_reg;
        idx_next   = idx_reg;
        s_next     = s_reg;
        co_next    = co_reg;
`ifdef ADD_OVERFLOW_EN
        ovf_next   = ovf_reg;
`endif
        case (state_reg)
            IDLE: state_next = IDLE;
            RUN: begin
                s_next     = s_merge;
                carry_next = sum[CHUNK];
                if (idx_reg == LAST) begin
                    co_next    = sum[CHUNK];
`ifdef ADD_OVERFLOW_EN
                    // carry into MSB is a^b^s at that bit; xor with carry out
                    ovf_next   = a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ sum[CHUNK-1] ^ sum[CHUNK];
`endif
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + IW'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (accept) begin
            a_next     = a;
            b_next     = sub ? ~b : b;
            carry_next = sub ? 1'b1 : ci;
            idx_next   = '0;
            state_next = RUN;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            s_reg     <= '0;
            co_reg    <= 1'b0;
`ifdef ADD_OVERFLOW_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            carry_reg <= carry_next;
            idx_reg   <= idx_next;
            s_reg     <= s_next;
            co_reg    <= co_next;
`ifdef ADD_OVERFLOW_EN
            ovf_reg   <= ovf_next;
`endif
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign s    = s_reg;
    assign co   = co_reg;
`ifdef ADD_OVERFLOW_EN
    assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_add_nbit_seq.sv
// Testbench for add_nbit_seq: 12-bit/4-bit-chunk instance plus a 12-bit/12-bit
// single-cycle instance sharing the same stimulus.
module tb_add_nbit_seq;

    logic        clk = 1'b0;
    logic        rst, start, sub, ci;
    logic [11:0] a, b;
    logic        busy1, done1, co1, busy2, done2, co2;
    logic [11:0] s1, s2;
`ifdef ADD_OVERFLOW_EN
    logic        ovf1, ovf2;
`endif
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    add_nbit_seq #(.WIDTH(12), .CHUNK(4)) dut1 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy1), .done(done1), .s(s1), .co(co1)
`ifdef ADD_OVERFLOW_EN
        , .ovf(ovf1)
`endif
    );

    add_nbit_seq #(.WIDTH(12), .CHUNK(12)) dut2 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy2), .done(done2), .s(s2), .co(co2)
`ifdef ADD_OVERFLOW_EN
        , .ovf(ovf2)
`endif
    );

    // Reference: full-width arithmetic; result bit 12 is the carry out.
    function automatic logic [12:0] model(input logic m_sub, input logic [11:0] m_a,
                                          input logic [11:0] m_b, input logic m_ci);
        logic [11:0] bb;
        bb = m_sub ? ~m_b : m_b;
        return {1'b0, m_a} + {1'b0, bb} + {12'd0, (m_sub ? 1'b1 : m_ci)};
    endfunction

    // Signed overflow: operands share a sign and the result sign differs.
    function automatic logic model_ovf(input logic m_sub, input logic [11:0] m_a,
                                       input logic [11:0] m_b, input logic m_ci);
        logic [11:0] bb;
        logic [12:0] r;
        bb = m_sub ? ~m_b : m_b;
        r  = model(m_sub, m_a, m_b, m_ci);
        return (m_a[11] == bb[11]) && (r[11] != m_a[11]);
    endfunction

    // One operation on the chunked instance, checked for latency, result and hold.
    task automatic do_op(input logic op_sub, input logic [11:0] op_a, input logic [11:0] op_b,
                         input logic op_ci, input logic [11:0] exp_s, input logic exp_co,
                         input logic exp_ovf, input string tag);
        int   n;
        logic busy_ok;
        @(negedge clk);
        sub = op_sub; a = op_a; b = op_b; ci = op_ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 12'($urandom); b = 12'($urandom); ci = 1'($urandom);
        n = 0;
        busy_ok = 1'b1;
        while (done1 !== 1'b1 && n < 10) begin
            if (busy1 !== 1'b1) busy_ok = 1'b0;
            n++;
            @(negedge clk);
        end
        total++;
        if (n != 3 || !busy_ok)
            begin bad++; $display("FAIL %s latency: busy_cycles=%0d busy_ok=%0b required 3/1", tag, n, busy_ok); end
        total++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || s1 !== exp_s || co1 !== exp_co)
            begin bad++; $display("FAIL %s result: done=%b busy=%b s=%h co=%b required done=1 busy=0 s=%h co=%b",
                                  tag, done1, busy1, s1, co1, exp_s, exp_co); end
`ifdef ADD_OVERFLOW_EN
        total++;
        if (ovf1 !== exp_ovf)
            begin bad++; $display("FAIL %s ovf: got=%b required=%b", tag, ovf1, exp_ovf); end
`else
        if (exp_ovf === 1'bx) $display("note: unknown ovf expectation");
`endif
        @(negedge clk);
        total++;
        if (done1 !== 1'b0 || busy1 !== 1'b0 || s1 !== exp_s || co1 !== exp_co)
            begin bad++; $display("FAIL %s hold: done=%b busy=%b s=%h co=%b required done=0 busy=0 s=%h co=%b",
                                  tag, done1, busy1, s1, co1, exp_s, exp_co); end
        $display("op %s: sub=%b a=%h b=%h ci=%b -> s=%h co=%b (exp %h %b)",
                 tag, op_sub, op_a, op_b, op_ci, s1, co1, exp_s, exp_co);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; ci = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || s1 !== 12'h000 || co1 !== 1'b0)
            begin bad++; $display("FAIL reset1: busy=%b done=%b s=%h co=%b required 0 0 000 0", busy1, done1, s1, co1); end
        total++;
        if (busy2 !== 1'b0 || done2 !== 1'b0 || s2 !== 12'h000 || co2 !== 1'b0)
            begin bad++; $display("FAIL reset2: busy=%b done=%b s=%h co=%b required 0 0 000 0", busy2, done2, s2, co2); end
`ifdef ADD_OVERFLOW_EN
        total++;
        if (ovf1 !== 1'b0) begin bad++; $display("FAIL reset_ovf: got=%b required=0", ovf1); end
`endif
        $display("reset: busy=%b done=%b s=%h co=%b", busy1, done1, s1, co1);
    endtask

    task automatic test_directed();
        do_op(1'b0, 12'h0FF, 12'h001, 1'b0, 12'h100, 1'b0, 1'b0, "carry_chunk");
        do_op(1'b0, 12'hFFF, 12'h000, 1'b1, 12'h000, 1'b1, 1'b0, "ripple_all");
        do_op(1'b1, 12'h005, 12'h007, 1'b0, 12'hFFE, 1'b0, 1'b0, "sub_borrow");
        do_op(1'b0, 12'h7FF, 12'h001, 1'b0, 12'h800, 1'b0, 1'b1, "signed_ovf");
    endtask

    task automatic test_random();
        logic        r_sub, r_ci;
        logic [11:0] r_a, r_b;
        logic [12:0] r;
        for (int i = 0; i < 30; i++) begin
            r_sub = 1'($urandom); r_ci = 1'($urandom);
            r_a = 12'($urandom); r_b = 12'($urandom);
            r = model(r_sub, r_a, r_b, r_ci);
            do_op(r_sub, r_a, r_b, r_ci, r[11:0], r[12], model_ovf(r_sub, r_a, r_b, r_ci), "random");
        end
    endtask

    task automatic test_ignore_busy();
        int n;
        @(negedge clk);
        sub = 1'b0; ci = 1'b0; a = 12'h001; b = 12'h001; start = 1'b1;
        @(negedge clk);
        a = 12'hAAA; b = 12'h111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 2;
        while (done1 !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != 4 || s1 !== 12'h002 || co1 !== 1'b0)
            begin bad++; $display("FAIL ignore_busy: cycles=%0d s=%h co=%b required 4 002 0", n, s1, co1); end
        @(negedge clk);
        total++;
        if (busy1 !== 1'b0 || done1 !== 1'b0)
            begin bad++; $display("FAIL ignore_rerun: busy=%b done=%b required 0 0", busy1, done1); end
        $display("ignore_busy: s=%h after %0d cycles", s1, n);
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        @(negedge clk);
        sub = 1'b0; ci = 1'b1; a = 12'hFFF; b = 12'hFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++;
        if (busy1 !== 1'b1) begin bad++; $display("FAIL mid_busy: busy=%b required 1", busy1); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (s1 !== 12'h000 || co1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0)
            begin bad++; $display("FAIL mid_reset: s=%h co=%b busy=%b done=%b required 000 0 0 0", s1, co1, busy1, done1); end
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done1 !== 1'b0 || busy1 !== 1'b0) saw_done = 1'b1;
        end
        total++;
        if (saw_done) begin bad++; $display("FAIL mid_no_done: activity=1 required 0"); end
        $display("reset_mid: s=%h co=%b", s1, co1);
        do_op(1'b0, 12'h123, 12'h321, 1'b0, 12'h444, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [12:0] r;
        logic        exp_done1, exp_done2;
        repeat (3) @(negedge clk);
        sub = 1'($urandom); ci = 1'($urandom); a = 12'($urandom); b = 12'($urandom);
        r = model(sub, a, b, ci);
        start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_done1 = (i % 4 == 3);
            exp_done2 = (i % 2 == 1);
            total++;
            if (done1 !== exp_done1 || busy1 !== !exp_done1)
                begin bad++; $display("FAIL b2b_n3 cycle %0d: done=%b busy=%b required %b %b", i, done1, busy1, exp_done1, !exp_done1); end
            total++;
            if (done2 !== exp_done2 || busy2 !== !exp_done2)
                begin bad++; $display("FAIL b2b_n1 cycle %0d: done=%b busy=%b required %b %b", i, done2, busy2, exp_done2, !exp_done2); end
            if (exp_done1) begin
                total++;
                if (s1 !== r[11:0] || co1 !== r[12])
                    begin bad++; $display("FAIL b2b_res1: s=%h co=%b required %h %b", s1, co1, r[11:0], r[12]); end
            end
            if (exp_done2) begin
                total++;
                if (s2 !== r[11:0] || co2 !== r[12])
                    begin bad++; $display("FAIL b2b_res2: s=%h co=%b required %h %b", s2, co2, r[11:0], r[12]); end
            end
            $display("b2b cycle %0d: done1=%b busy1=%b done2=%b busy2=%b", i, done1, busy1, done2, busy2);
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_busy();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/add_nbit_seq.md
ADD_NBIT_SEQ -- requirements
Module: add_nbit_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 12, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per clock. WIDTH SHALL be an integer multiple of CHUNK. NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous to clk and active-high.
REQ-005 SHALL have port start  input  1  request a new operation; sampled only in IDLE or DONE.
REQ-006 SHALL have port sub  input  1  0 = a+b+ci; 1 = a-b (a + ~b + 1, ci ignored); sampled with start.
REQ-007 SHALL have port a  input  WIDTH  operand A; sampled with start.
REQ-008 SHALL have port b  input  WIDTH  operand B; sampled with start.
REQ-009 SHALL have port ci  input  1  carry-in; sampled with start.
REQ-010 SHALL have port busy  output  1  high while in RUN.
REQ-011 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-012 SHALL have port s  output  WIDTH  sum/difference, registered.
REQ-013 SHALL have port co  output  1  final carry-out (for sub: 1 = no borrow), registered.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 In IDLE or DONE with start=1, SHALL latch a, b (or ~b if sub), and carry = ci (or 1 if sub), clear the chunk index to 0, and go to RUN.
REQ-016 In RUN, each edge SHALL add chunk k of the latched operands plus the carry register, write bits [k*CHUNK +: CHUNK] of s, update the carry register and increment k.
REQ-017 After chunk NCHUNK-1, SHALL write co from the final carry and go to DONE. The result is therefore valid N = NCHUNK clocks after the start edge.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle. Without start, the FSM SHALL return to IDLE on the next edge.
REQ-019 start in DONE SHALL be accepted (back-to-back); busy SHALL be 1 on the following cycle.
REQ-020 start while in RUN SHALL be ignored; operands in flight SHALL NOT change.
REQ-021 s and co SHALL be guaranteed only while done=1. After that they SHALL hold until the next accepted start. Partial chunk writes SHALL be visible during RUN.
REQ-022 busy=1 exactly in RUN. done=1 exactly in DONE.
REQ-023 With CHUNK=WIDTH, SHALL complete in a single RUN cycle (N=1).

Reset
REQ-024 rst=1 at any edge, including mid-RUN, SHALL force IDLE and set s=0, co=0, busy=0, done=0, carry=0, index=0, and ovf=0 when present.
REQ-025 rst SHALL have priority over start. An operation interrupted by reset SHALL be discarded, with no done pulse.

Configuration
REQ-026 Macro ADD_OVERFLOW_EN defined: SHALL add output port ovf (1 bit, registered). It SHALL be written with co and carry-out of the MSB chunk's top bit, i.e. the two's-complement signed overflow: (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1). It SHALL be valid with done and hold like s.
REQ-027 Macro undefined: the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=12, CHUNK=4, N=3)
REQ-028 a=0x0FF, b=0x001, ci=0, sub=0, start -> busy for 3 cycles, then done=1 with s=0x100, co=0.
REQ-029 a=0xFFF, b=0x000, ci=1 -> carry ripples through all chunks; s=0x000, co=1.
REQ-030 sub=1, a=0x005, b=0x007 -> s=0xFFE, co=0. With ADD_OVERFLOW_EN: ovf=0. Then a=0x7FF, b=0x001, sub=0 -> s=0x800, ovf=1.
REQ-031 start a=0x001, b=0x001; one cycle later start a=0xAAA, b=0x111 while busy -> done with s=0x002; the second request is ignored.
REQ-032 rst asserted in the 2nd RUN cycle -> next cycle s=0, co=0, busy=0, and no done pulse. Then a=0x123, b=0x321 -> s=0x444 after 3 cycles.
REQ-033 start held high continuously -> done pulses every 4th cycle, and busy is low only in DONE cycles; repeat with CHUNK=12 -> done every 2nd cycle.
